// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
//
// Resolves data-memory wait, multicycle execute ops, load-use and fetch wait
// (in that priority order) into per-stage load enables and bubble inserts. It
// also owns the branch redirect when a taken branch meets an outstanding fetch.
//
// Optional feature macro: HAZARD_PERF_EN (adds stall/flush performance counters).
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   i_req, i_data_ok                 fetch request outstanding / data returned
//   d_req, d_data_ok                 M-stage data request outstanding / data returned
//   mc_start                         E-stage multicycle op issued (1-cycle pulse)
//   ex_is_load, ex_rd                E-stage load flag and destination register
//   id_rs1, id_rs2                   D-stage source registers
//   id_use_rs1, id_use_rs2           D-stage source actually read
//   branch_taken, pcbranch           E-stage taken branch and its target
//   pc_en..wreg_en                   pipeline register load enables
//   dreg_flush..wreg_flush           load a bubble instead of the stage input
//   redirect_valid, redirect_pc      pcselect must take redirect_pc
//   mc_busy                          multicycle op in progress
//   perf_stall_cycles                (HAZARD_PERF_EN) cycles with pc_en=0
//   perf_flush_events                (HAZARD_PERF_EN) branch-caused E flushes
module pipe_hazard_ctrl #(
    parameter int unsigned MC_CYCLES  = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic                  i_data_ok,
    input  logic                  d_req,
    input  logic                  d_data_ok,
    input  logic                  mc_start,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  branch_taken,
    input  logic [63:0]           pcbranch,
    output logic                  pc_en,
    output logic                  dreg_en,
    output logic                  ereg_en,
    output logic                  mreg_en,
    output logic                  wreg_en,
    output logic                  dreg_flush,
    output logic                  ereg_flush,
    output logic                  mreg_flush,
    output logic                  wreg_flush,
    output logic                  redirect_valid,
    output logic [63:0]           redirect_pc,
    output logic                  mc_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_events
`endif
);

    localparam int unsigned CntW = $clog2(MC_CYCLES);
    localparam logic [CntW-1:0] CntLoad = CntW'(MC_CYCLES - 1);

    typedef enum logic {
        RIdle,
        RWait
    } redir_state_e;

    redir_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     rpc_q, rpc_d;

    logic dwait, mcw, lu, iwait, br_take;

    always_comb begin
        dwait = d_req & ~d_data_ok;
        mcw   = mc_start | (cnt_q != '0);
        lu    = ex_is_load & (ex_rd != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        iwait = i_req & ~i_data_ok;
        // A branch only resolves when E advances; in RWait E holds a bubble,
        // so any branch_taken seen there is spurious and dropped.
        br_take = branch_taken & ~dwait & ~mcw & (state_q == RIdle);
    end

    assign mc_busy = mcw;

    // Enables / flushes / redirect
    always_comb begin
        pc_en          = 1'b1;
        dreg_en        = 1'b1;
        ereg_en        = 1'b1;
        mreg_en        = 1'b1;
        wreg_en        = 1'b1;
        dreg_flush     = 1'b0;
        ereg_flush     = 1'b0;
        mreg_flush     = 1'b0;
        wreg_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = rpc_q;

        if (dwait) begin
            pc_en      = 1'b0;
            dreg_en    = 1'b0;
            ereg_en    = 1'b0;
            mreg_en    = 1'b0;
            wreg_flush = 1'b1;
        end else if (mcw) begin
            pc_en      = 1'b0;
            dreg_en    = 1'b0;
            ereg_en    = 1'b0;
            mreg_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            dreg_en    = 1'b0;
            ereg_flush = 1'b1;
        end else if (iwait) begin
            pc_en      = 1'b0;
            dreg_flush = 1'b1;
        end

        // Taken branch squashes the wrong-path instructions in D and E, which
        // also overrides a load-use stall on the now-dead D instruction.
        if (br_take) begin
            dreg_en    = 1'b1;
            dreg_flush = 1'b1;
            ereg_en    = 1'b1;
            ereg_flush = 1'b1;
            if (!iwait) begin
                redirect_valid = 1'b1;
                redirect_pc    = pcbranch;
                pc_en          = 1'b1;
            end
        end

        // Waiting for the stale fetch to drain: hold PC, bubble D, and take
        // the latched target once the discarded instruction returns.
        if (state_q == RWait) begin
            pc_en      = 1'b0;
            dreg_en    = 1'b1;
            dreg_flush = 1'b1;
            if (i_data_ok) begin
                redirect_valid = 1'b1;
                pc_en          = 1'b1;
            end
        end
    end

    // Next state: redirect FSM, latched target, multicycle counter
    always_comb begin
        state_d = state_q;
        rpc_d   = rpc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            RIdle: begin
                if (br_take && iwait) begin
                    rpc_d   = pcbranch;
                    state_d = RWait;
                end
            end
            RWait: begin
                if (i_data_ok) begin
                    state_d = RIdle;
                end
            end
            default: state_d = RIdle;
        endcase

        // The multicycle unit counts down on its own, even while M stalls;
        // a start pulse during an active op is ignored.
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (mc_start) begin
            cnt_d = CntLoad;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RIdle;
            rpc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rpc_q   <= rpc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (!pc_en) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (br_take) begin
                perf_flush_events <= perf_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle hazard
// vectors plus hand-written multicycle, data-wait, branch-redirect and reset
// sequences. Built with MC_CYCLES=4.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MC = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, i_data_ok, d_req, d_data_ok, mc_start;
    logic        ex_is_load;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2, branch_taken;
    logic [63:0] pcbranch;
    logic        pc_en, dreg_en, ereg_en, mreg_en, wreg_en;
    logic        dreg_flush, ereg_flush, mreg_flush, wreg_flush;
    logic        redirect_valid, mc_busy;
    logic [63:0] redirect_pc;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

    logic [8:0]  ctl;
    assign ctl = {pc_en, dreg_en, ereg_en, mreg_en, wreg_en,
                  dreg_flush, ereg_flush, mreg_flush, wreg_flush};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MC_CYCLES  (MC),
        .REG_ADDR_W (5)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_req          (i_req),
        .i_data_ok      (i_data_ok),
        .d_req          (d_req),
        .d_data_ok      (d_data_ok),
        .mc_start       (mc_start),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .branch_taken   (branch_taken),
        .pcbranch       (pcbranch),
        .pc_en          (pc_en),
        .dreg_en        (dreg_en),
        .ereg_en        (ereg_en),
        .mreg_en        (mreg_en),
        .wreg_en        (wreg_en),
        .dreg_flush     (dreg_flush),
        .ereg_flush     (ereg_flush),
        .mreg_flush     (mreg_flush),
        .wreg_flush     (wreg_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mc_busy        (mc_busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
`endif
    );

    // ctl = {pc,d,e,m,w en, d,e,m,w flush}
    localparam logic [8:0] CNone = 9'b11111_0000;
    localparam logic [8:0] CLu   = 9'b00111_0100;
    localparam logic [8:0] CIw   = 9'b01111_1000;
    localparam logic [8:0] CDw   = 9'b00001_0001;
    localparam logic [8:0] CMc   = 9'b00011_0010;
    localparam logic [8:0] CBr   = 9'b11111_1100;
    localparam logic [8:0] CBrIw = 9'b01111_1100;

    typedef struct {
        logic        i_req, i_ok, d_req, d_ok, ld;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, br;
        logic [63:0] pcb;
        logic [8:0]  ctl;
        logic        rv;
        logic [63:0] rpc;
    } vec_t;

    vec_t vecs[15];

    task automatic clear_inputs();
        i_req = 0; i_data_ok = 0; d_req = 0; d_data_ok = 0; mc_start = 0;
        ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; branch_taken = 0; pcbranch = 0;
    endtask

    task automatic check(input string name, input logic [8:0] ec, input logic erv,
                         input logic chk_rpc, input logic [63:0] erpc, input logic ebusy);
        checks++;
        if (ctl !== ec || redirect_valid !== erv || mc_busy !== ebusy ||
            (chk_rpc && redirect_pc !== erpc)) begin
            errors++;
            $display("FAIL %s: got ctl=%b rv=%b rpc=%h busy=%b, want ctl=%b rv=%b rpc=%h busy=%b",
                     name, ctl, redirect_valid, redirect_pc, mc_busy, ec, erv, erpc, ebusy);
        end
    endtask

    initial begin
        //        ireq iok dreq dok ld  rd rs1 rs2 u1 u2 br pcb           ctl    rv rpc
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,          CNone, 0, 64'h0};
        vecs[1]  = '{0, 0, 0, 0, 1, 5, 5, 0, 1, 0, 0, 64'h0,          CLu,   0, 64'h0};
        vecs[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 64'h0,          CNone, 0, 64'h0};
        vecs[3]  = '{0, 0, 0, 0, 1, 7, 3, 7, 0, 1, 0, 64'h0,          CLu,   0, 64'h0};
        vecs[4]  = '{0, 0, 0, 0, 1, 5, 5, 5, 0, 0, 0, 64'h0,          CNone, 0, 64'h0};
        vecs[5]  = '{0, 0, 0, 0, 0, 5, 5, 0, 1, 0, 0, 64'h0,          CNone, 0, 64'h0};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,          CIw,   0, 64'h0};
        vecs[7]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,          CNone, 0, 64'h0};
        vecs[8]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,          CDw,   0, 64'h0};
        vecs[9]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 64'h0,          CNone, 0, 64'h0};
        vecs[10] = '{1, 0, 1, 0, 1, 5, 5, 0, 1, 0, 0, 64'h0,          CDw,   0, 64'h0};
        vecs[11] = '{1, 0, 0, 0, 1, 5, 5, 0, 1, 0, 0, 64'h0,          CLu,   0, 64'h0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0040,  CBr,   1, 64'h8000_0040};
        vecs[13] = '{0, 0, 0, 0, 1, 5, 5, 0, 1, 0, 1, 64'h1234,       CBr,   1, 64'h1234};
        vecs[14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1234,       CDw,   0, 64'h0};

        clear_inputs();
        resetn = 1'b0;
        #3;
        check("reset", CNone, 1'b0, 1'b1, 64'h0, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            i_req = vecs[i].i_req; i_data_ok = vecs[i].i_ok;
            d_req = vecs[i].d_req; d_data_ok = vecs[i].d_ok;
            ex_is_load = vecs[i].ld; ex_rd = vecs[i].rd;
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2;
            branch_taken = vecs[i].br; pcbranch = vecs[i].pcb;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].rv, 1'b1, vecs[i].rpc, 1'b0);
        end

        // Multicycle: busy for exactly MC cycles; a second start mid-op is ignored.
        @(posedge clk); #1;
        clear_inputs();
        mc_start = 1;
        @(negedge clk);
        check("mc0", CMc, 1'b0, 1'b0, 64'h0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            mc_start = (i == 2);
            @(negedge clk);
            check($sformatf("mc%0d", i), (i < 4) ? CMc : CNone, 1'b0, 1'b0, 64'h0, i < 4);
        end

        // Data wait on top of a multicycle op; the counter keeps running.
        @(posedge clk); #1;
        clear_inputs();
        mc_start = 1;
        @(negedge clk);
        check("dw_mc0", CMc, 1'b0, 1'b0, 64'h0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            mc_start = 0;
            d_req = (i < 4);
            d_data_ok = 0;
            @(negedge clk);
            check($sformatf("dw_mc%0d", i), (i < 4) ? CDw : CNone, 1'b0, 1'b0, 64'h0, i < 4);
        end

        // Branch while a fetch is outstanding; fetch returns two cycles later.
        @(posedge clk); #1;
        clear_inputs();
        branch_taken = 1; pcbranch = 64'h8000_0100; i_req = 1;
        @(negedge clk);
        check("brw0", CBrIw, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk); #1;
        branch_taken = 0; pcbranch = 64'h0;
        @(negedge clk);
        check("brw1", CIw, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk); #1;
        i_data_ok = 1;
        @(negedge clk);
        check("brw2", 9'b11111_1000, 1'b1, 1'b1, 64'h8000_0100, 1'b0);
        @(posedge clk); #1;
        i_data_ok = 0; i_req = 0;
        @(negedge clk);
        check("brw3", CNone, 1'b0, 1'b0, 64'h0, 1'b0);

        // Reset asserted while waiting to redirect; the redirect is lost.
        @(posedge clk); #1;
        branch_taken = 1; pcbranch = 64'h8000_0200; i_req = 1;
        @(negedge clk);
        check("rstw0", CBrIw, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge clk); #1;
        branch_taken = 0; pcbranch = 64'h0;
        @(negedge clk);
        check("rstw1", CIw, 1'b0, 1'b0, 64'h0, 1'b0);
        #1;
        resetn = 0;
        i_data_ok = 1;
        #1;
        check("rstw_async", CNone, 1'b0, 1'b1, 64'h0, 1'b0);
        @(posedge clk); #1;
        resetn = 1;
        @(negedge clk);
        check("rstw_after", CNone, 1'b0, 1'b1, 64'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: drives enables and bubble-inserts for pcreg, dreg, ereg, mreg and wreg.
- Resolves four hazard sources by fixed priority: data-memory wait, multicycle execute op, load-use, instruction-fetch wait.
- Owns the branch-redirect sequence when a taken branch arrives while an instruction fetch is still outstanding.

Parameters:
MC_CYCLES, 64, execute-stage multicycle (mul/div) latency in cycles, >=2
REG_ADDR_W, 5, register address width (creg_addr_t)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous reset, active-low
i_req  in  1  fetch request outstanding
i_data_ok  in  1  fetch data returned this cycle
d_req  in  1  memory-stage data request outstanding
d_data_ok  in  1  data returned this cycle
mc_start  in  1  E-stage multicycle op issued (1-cycle pulse)
ex_is_load  in  1  E-stage instr is a load
ex_rd  in  REG_ADDR_W  E-stage destination
id_rs1, id_rs2  in  REG_ADDR_W each  D-stage sources
id_use_rs1, id_use_rs2  in  1 each  D-stage source actually read
branch_taken  in  1  E-stage taken branch/jump
pcbranch  in  64  branch target
pc_en, dreg_en, ereg_en, mreg_en, wreg_en  out  1 each  register load enables
dreg_flush, ereg_flush, mreg_flush, wreg_flush  out  1 each  load bubble instead of input
redirect_valid  out  1  pcselect must use redirect_pc
redirect_pc  out  64  latched branch target
mc_busy  out  1  multicycle op in progress

Behaviour:
- Async reset (resetn=0): mc counter=0, redirect FSM=R_IDLE, redirect_pc=0. All *_en=1, all *_flush=0, redirect_valid=0, mc_busy=0. Outputs combinational from state+inputs, so these hold throughout reset.
- Hazard conditions:
  - dwait = d_req & ~d_data_ok
  - mcw = mc_start | (cnt!=0)
  - lu = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - iwait = i_req & ~i_data_ok
- Priority, highest first; the first true row applies:
  - dwait: pc,dreg,ereg,mreg en=0; wreg_flush=1.
  - mcw: pc,dreg,ereg en=0; mreg_flush=1; mreg_en=wreg_en=1.
  - lu: pc,dreg en=0; ereg_flush=1.
  - iwait: pc_en=0; dreg_flush=1.
  - none: all en=1, no flush.
- Any flush implies the corresponding en=1.
- Branch is honoured only when E advances (no dwait, no mcw):
  - Always: dreg_flush=ereg_flush=1.
  - If ~iwait: redirect_valid=1 and redirect_pc=pcbranch combinationally, pc_en=1.
  - If iwait: latch pcbranch, go R_WAIT.
- Redirect FSM R_IDLE/R_WAIT:
  - In R_WAIT: pc_en=0 and dreg_flush=1 every cycle.
  - On i_data_ok in R_WAIT: returned instr discarded (dreg_flush=1), redirect_valid=1 with latched pc, pc_en=1, next state R_IDLE.
  - branch_taken while in R_WAIT cannot occur (E is bubbled) and is ignored.
- Multicycle counter:
  - mc_start with cnt==0 loads cnt=MC_CYCLES-1.
  - Decrements each cycle while nonzero, including under dwait; the unit runs independently.
  - mc_busy=mcw.
  - mc_start while cnt!=0 is illegal; it is ignored.
- Reset mid-operation: counter and FSM cleared immediately; a pending redirect is lost. Fetch restarts from the reset PC.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_events[31:0].
  - perf_stall_cycles counts cycles with pc_en=0.
  - perf_flush_events counts cycles with ereg_flush=1 caused by branch.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent, no other change.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1, no other hazard -> one cycle pc_en=0, dreg_en=0, ereg_flush=1. Same with ex_rd=0 -> no stall.
- Multicycle: mc_start pulse, MC_CYCLES=4 -> mc_busy high exactly 4 cycles; pc/dreg/ereg en=0 and mreg_flush=1 for those 4 cycles; normal on cycle 5.
- Data wait over multicycle: d_req=1, d_data_ok=0 for 3 cycles during mc -> wreg_flush=1, mreg_en=0 all 3 cycles; counter still expires on schedule.
- Branch, no fetch pending: branch_taken=1, pcbranch=0x8000_0040 -> same cycle redirect_valid=1, redirect_pc=0x8000_0040, dreg_flush=ereg_flush=1.
- Branch with fetch pending: branch_taken, pcbranch=0x8000_0100, i_data_ok arrives 2 cycles later -> pc_en=0 for 2 cycles; then redirect_valid=1 with 0x8000_0100 and dreg_flush=1 on the i_data_ok cycle; FSM back to R_IDLE.
- Reset mid-R_WAIT: resetn=0 asynchronously -> redirect_valid=0, all en=1 immediately; no redirect after release.
